// File: rtl/sysbus_arbiter.sv
// Two-client (instruction/data) arbiter for the single system-bus master port.
// Round-robin grant; ownership is held through the request handshake and the full response burst.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  output logic                      i_reqack,
  output logic                      i_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] i_resp,
  output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
  input  logic                      i_respack,
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  output logic                      d_reqack,
  output logic                      d_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] d_resp,
  output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
  input  logic                      d_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int CW = $clog2(BEATS) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // owner/last encoding: 0 = instruction client, 1 = data client
  logic [1:0]    state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          last_reg, last_next;
  logic [CW-1:0] count_reg, count_next;

  logic owner_reqcyc;
  logic owner_respack;
  logic in_req;
  logic in_resp;
  logic req_ack;

  assign owner_reqcyc  = owner_reg ? d_reqcyc : i_reqcyc;
  assign owner_respack = owner_reg ? d_respack : i_respack;

  // Gating with reset keeps every output at zero while reset is held, even mid-burst.
  assign in_req  = !reset && (state_reg == ST_REQ);
  assign in_resp = !reset && (state_reg == ST_RESP);

  assign bus_reqcyc = in_req && owner_reqcyc;
  assign bus_req    = in_req ? (owner_reg ? d_req : i_req) : '0;
  assign bus_reqtag = in_req ? (owner_reg ? d_reqtag : i_reqtag) : '0;
  assign req_ack    = in_req && owner_reqcyc && bus_reqack;
  assign i_reqack   = req_ack && !owner_reg;
  assign d_reqack   = req_ack && owner_reg;

  assign bus_respack = in_resp && bus_respcyc && owner_respack;
  assign i_respcyc   = in_resp && !owner_reg && bus_respcyc;
  assign i_resp      = (in_resp && !owner_reg) ? bus_resp : '0;
  assign i_resptag   = (in_resp && !owner_reg) ? bus_resptag : '0;
  assign d_respcyc   = in_resp && owner_reg && bus_respcyc;
  assign d_resp      = (in_resp && owner_reg) ? bus_resp : '0;
  assign d_resptag   = (in_resp && owner_reg) ? bus_resptag : '0;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_reqcyc && d_reqcyc) begin
          owner_next = !last_reg;
          last_next  = !last_reg;
          state_next = ST_REQ;
        end else if (i_reqcyc || d_reqcyc) begin
          owner_next = d_reqcyc;
          last_next  = d_reqcyc;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!owner_reqcyc) begin
          state_next = ST_IDLE;
        end else if (bus_reqack) begin
          count_next = '0;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_respack) begin
          count_next = count_reg + 1'b1;
          if (count_reg == CW'(BEATS - 1)) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: a directed vector table, hand-written corner sequences,
// and random traffic checked cycle by cycle against a transaction-level model.
module tb_sysbus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NB = 8;

  logic          clk, reset;
  logic          i_reqcyc, i_reqack, i_respcyc, i_respack;
  logic [DW-1:0] i_req, i_resp;
  logic [TW-1:0] i_reqtag, i_resptag;
  logic          d_reqcyc, d_reqack, d_respcyc, d_respack;
  logic [DW-1:0] d_req, d_resp;
  logic [TW-1:0] d_reqtag, d_resptag;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [DW-1:0] bus_req, bus_resp;
  logic [TW-1:0] bus_reqtag, bus_resptag;

  sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
    .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(i_respack),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
    .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag), .d_respack(d_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Transaction-level model: who owns the bus, whether the request was accepted, beats still owed.
  int m_owner = 0;   // 0 none, 1 instruction, 2 data
  bit m_acked = 0;
  int m_left  = 0;
  int m_last  = 2;

  function automatic logic [236:0] model_out();
    logic b_rc = 0, b_ra = 0, ia = 0, ic = 0, da = 0, dc = 0, rc;
    logic [DW-1:0] b_req = 0, ir = 0, dr = 0;
    logic [TW-1:0] b_tag = 0, it = 0, dt = 0;
    if (!reset && m_owner != 0) begin
      if (!m_acked) begin
        rc    = (m_owner == 1) ? i_reqcyc : d_reqcyc;
        b_rc  = rc;
        b_req = (m_owner == 1) ? i_req : d_req;
        b_tag = (m_owner == 1) ? i_reqtag : d_reqtag;
        if (m_owner == 1) ia = rc & bus_reqack;
        else              da = rc & bus_reqack;
      end else if (m_owner == 1) begin
        ic = bus_respcyc; ir = bus_resp; it = bus_resptag;
        b_ra = bus_respcyc & i_respack;
      end else begin
        dc = bus_respcyc; dr = bus_resp; dt = bus_resptag;
        b_ra = bus_respcyc & d_respack;
      end
    end
    return {b_rc, b_req, b_tag, b_ra, ia, ic, ir, it, da, dc, dr, dt};
  endfunction

  function automatic logic [236:0] dut_out();
    return {bus_reqcyc, bus_req, bus_reqtag, bus_respack,
            i_reqack, i_respcyc, i_resp, i_resptag,
            d_reqack, d_respcyc, d_resp, d_resptag};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_owner = 0; m_acked = 0; m_left = 0; m_last = 2;
    end else if (m_owner == 0) begin
      if (i_reqcyc && d_reqcyc) m_owner = (m_last == 1) ? 2 : 1;
      else if (i_reqcyc)        m_owner = 1;
      else if (d_reqcyc)        m_owner = 2;
      if (m_owner != 0) m_last = m_owner;
      m_acked = 0;
    end else if (!m_acked) begin
      if (!((m_owner == 1) ? i_reqcyc : d_reqcyc)) m_owner = 0;
      else if (bus_reqack) begin m_acked = 1; m_left = NB; end
    end else if (bus_respcyc && ((m_owner == 1) ? i_respack : d_respack)) begin
      m_left--;
      if (m_left == 0) begin
        $display("txn done: client=%s cycle=%0d", (m_owner == 1) ? "I" : "D", cyc);
        m_owner = 0;
      end
    end
  endtask

  task automatic sample(input string tag);
    logic [236:0] e, a;
    @(negedge clk);
    e = model_out();
    a = dut_out();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, a, e);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic clear_inputs();
    reset = 0; i_reqcyc = 0; d_reqcyc = 0; i_respack = 0; d_respack = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    i_req = 64'h1000; i_reqtag = 13'h5; d_req = 64'h2000; d_reqtag = 13'h7;
  endtask

  typedef struct {
    logic rst, irc, back, brc, ira;
    logic [DW-1:0] bd;
    logic e_rc;
    logic [DW-1:0] e_req;
    logic e_ia, e_ic;
    logic [DW-1:0] e_ir;
    logic e_bra;
  } vec_t;

  function automatic vec_t mk(logic rst, logic irc, logic back, logic brc, logic ira,
                              logic [DW-1:0] bd, logic e_rc, logic [DW-1:0] e_req,
                              logic e_ia, logic e_ic, logic [DW-1:0] e_ir, logic e_bra);
    vec_t v;
    v.rst = rst; v.irc = irc; v.back = back; v.brc = brc; v.ira = ira; v.bd = bd;
    v.e_rc = e_rc; v.e_req = e_req; v.e_ia = e_ia; v.e_ic = e_ic; v.e_ir = e_ir; v.e_bra = e_bra;
    return v;
  endfunction

  vec_t vt[12];
  int grants[$];
  int gcyc[$];
  logic [DW-1:0] delivered[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int held, acks, early, nack, k, stall, zeros;
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;

    // Directed vectors: reset, single instruction transaction, then idle with a stray beat.
    vt[0]  = mk(1, 0, 0, 0, 0, 64'h0,  0, 64'h0,    0, 0, 64'h0, 0);
    vt[1]  = mk(0, 1, 0, 0, 0, 64'h0,  0, 64'h0,    0, 0, 64'h0, 0);
    vt[2]  = mk(0, 1, 1, 0, 0, 64'h0,  1, 64'h1000, 1, 0, 64'h0, 0);
    for (int b = 1; b <= 8; b++)
      vt[2+b] = mk(0, 0, 0, 1, 1, 64'(b * 17), 0, 64'h0, 0, 1, 64'(b * 17), 1);
    vt[11] = mk(0, 0, 0, 1, 1, 64'h99, 0, 64'h0,    0, 0, 64'h0, 0);
    for (int r = 0; r < 12; r++) begin
      reset = vt[r].rst; i_reqcyc = vt[r].irc; bus_reqack = vt[r].back;
      bus_respcyc = vt[r].brc; i_respack = vt[r].ira; bus_resp = vt[r].bd;
      sample("tbl_model");
      check($sformatf("tbl_row%0d", r),
            64'({bus_reqcyc, bus_req[31:0], i_reqack, i_respcyc, i_resp[15:0], d_respcyc, bus_respack}),
            64'({vt[r].e_rc, vt[r].e_req[31:0], vt[r].e_ia, vt[r].e_ic, vt[r].e_ir[15:0], 1'b0, vt[r].e_bra}));
      check($sformatf("tbl_row%0d_hi", r), {bus_req[63:32], i_resp[63:16]}, 64'h0);
      advance();
    end

    // Simultaneous requests alternate I, D, I, D with 10 cycles between grants.
    clear_inputs(); reset = 1; step("rr_rst");
    clear_inputs();
    i_reqcyc = 1; d_reqcyc = 1; bus_reqack = 1; bus_respcyc = 1; i_respack = 1; d_respack = 1;
    for (int c = 0; c < 40; c++) begin
      bus_resp = 64'(c); bus_resptag = 13'(c);
      sample("rr");
      if (i_reqack) begin grants.push_back(1); gcyc.push_back(cyc); end
      if (d_reqack) begin grants.push_back(2); gcyc.push_back(cyc); end
      advance();
    end
    check("rr_count", 64'(grants.size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_grant%0d", j), 64'(grants[j]), (j % 2 == 0) ? 64'd1 : 64'd2);
      if (j > 0) check($sformatf("rr_gap%0d", j), 64'(gcyc[j] - gcyc[j-1]), 64'd10);
    end
    clear_inputs(); step("rr_idle");

    // Ack delayed 5 cycles: request held stable, no response leaks before the ack.
    i_reqcyc = 1; i_req = 64'h3000; bus_respcyc = 1; bus_resp = 64'hdead; i_respack = 1;
    step("dly_grant");
    held = 0; acks = 0; early = 0;
    for (int c = 0; c < 6; c++) begin
      bus_reqack = (c == 5);
      sample("dly_wait");
      if (c < 5 && bus_reqcyc && bus_req == 64'h3000) held++;
      if (i_respcyc) early++;
      if (i_reqack) acks++;
      advance();
    end
    bus_reqack = 0; i_reqcyc = 0;
    for (int c = 0; c < 8; c++) begin
      sample("dly_beats");
      if (i_reqack) acks++;
      advance();
    end
    check("dly_held", 64'(held), 64'd5);
    check("dly_acks", 64'(acks), 64'd1);
    check("dly_early_resp", 64'(early), 64'd0);
    clear_inputs(); step("dly_idle");

    // Client stalls 3 cycles at beat 4; all 8 beats still arrive in order.
    i_reqcyc = 1; step("stall_grant");
    bus_reqack = 1; step("stall_ack");
    i_reqcyc = 0; bus_reqack = 0; bus_respcyc = 1;
    k = 0; stall = 0; nack = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      i_respack = !(k == 3 && stall < 3);
      if (!i_respack) stall++;
      bus_resp = 64'h100 + 64'(k);
      sample("stall_beats");
      if (!bus_respack) nack++;
      if (i_respcyc && i_respack) delivered.push_back(i_resp);
      if (bus_respack) k++;
      advance();
    end
    check("stall_nack", 64'(nack), 64'd3);
    check("stall_count", 64'(delivered.size()), 64'd8);
    for (int j = 0; j < 8; j++) check($sformatf("stall_beat%0d", j), delivered[j], 64'h100 + 64'(j));
    i_respack = 1; sample("stall_after");
    check("stall_after_respack", 64'(bus_respack), 64'd0);
    advance();
    clear_inputs(); step("stall_idle");

    // Reset at beat 3 of a data burst; later bus beats are not acknowledged.
    d_reqcyc = 1; step("rst_grant");
    bus_reqack = 1; step("rst_ack");
    d_reqcyc = 0; bus_reqack = 0; bus_respcyc = 1; d_respack = 1;
    step("rst_b1"); step("rst_b2");
    reset = 1; sample("rst_b3");
    check("rst_during", {dut_out()} == '0 ? 64'd0 : 64'd1, 64'd0);
    advance();
    reset = 0; zeros = 0;
    for (int c = 0; c < 4; c++) begin
      sample("rst_after");
      if (!bus_respack && !d_respcyc && !i_respcyc) zeros++;
      advance();
    end
    check("rst_after_quiet", 64'(zeros), 64'd4);
    clear_inputs(); step("rst_idle");

    // Data owner withdraws before ack; the pending instruction request is then granted.
    d_reqcyc = 1; step("drop_grant");
    d_reqcyc = 0; i_reqcyc = 1; sample("drop_req");
    check("drop_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("drop_d_reqack", 64'(d_reqack), 64'd0);
    advance();
    step("drop_idle");
    sample("drop_i_req");
    check("drop_i_granted", {63'd0, bus_reqcyc} + (bus_req == 64'h1000 ? 64'd0 : 64'd2), 64'd1);
    advance();
    clear_inputs(); reset = 1; step("drop_rst");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      i_reqcyc    = ($urandom_range(0, 9) < 6);
      d_reqcyc    = ($urandom_range(0, 9) < 6);
      i_req       = {$urandom, $urandom};
      d_req       = {$urandom, $urandom};
      i_reqtag    = 13'($urandom);
      d_reqtag    = 13'($urandom);
      bus_reqack  = ($urandom_range(0, 9) < 3);
      bus_respcyc = ($urandom_range(0, 9) < 6);
      bus_resp    = {$urandom, $urandom};
      bus_resptag = 13'($urandom);
      i_respack   = ($urandom_range(0, 3) != 0);
      d_respack   = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
